// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequencer and its ALU.
package fib_pkg;

  // Controller states. SET runs once per job; GAP2, ADD, GAP1, DEC form the loop.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SET  = 3'd1,
    ST_GAP1 = 3'd2,
    ST_DEC  = 3'd3,
    ST_GAP2 = 3'd4,
    ST_ADD  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // ALU opcode encoding. 000 is the idle/no-op code driven in every gap state.
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SET  = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_COPY = 3'b111;

endpackage

// File: rtl/fib_controller.sv
// Sequencer that computes F(n) mod 2^size by stepping a shared ALU.
//
// Handshake: start is a request sampled only while IDLE (busy low); the
// cycle after it is sampled busy rises and n is captured. done is a single
// cycle pulse in the DONE state; result and overflow are valid from that
// cycle until the next accepted start. start while busy has no effect.
//
// The ALU only re-evaluates when its opcode changes, so each real operation
// is preceded by a gap cycle that drives OP_NOP with the next operands
// already set up on alu_a/alu_b.
module fib_controller
  import fib_pkg::*;
#(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [size-1:0] n,
  input  logic [size-1:0] alu_o,
  input  logic            alu_zero,
  output logic [2:0]      alu_opcode,
  output logic [size-1:0] alu_a,
  output logic [size-1:0] alu_b,
  output logic [size-1:0] result,
  output logic            overflow,
  output logic            busy,
  output logic            done,
  output state_t          state_dbg
);

  state_t          state;
  state_t          next_state;
  logic [size-1:0] prev;
  logic [size-1:0] curr;
  logic [size-1:0] cnt;
  logic [size-1:0] result_q;
  logic            ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and ALU drive; outputs depend only on state and registers.
  always_comb begin
    next_state = state;
    alu_opcode = OP_NOP;
    alu_a      = '0;
    alu_b      = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (n == '0) ? ST_DONE : ST_SET;
        end
      end
      ST_SET: begin
        alu_opcode = OP_SET;
        next_state = ST_GAP1;
      end
      ST_GAP1: begin
        alu_a      = cnt;
        next_state = ST_DEC;
      end
      ST_DEC: begin
        alu_opcode = OP_DEC;
        alu_a      = cnt;
        next_state = alu_zero ? ST_DONE : ST_GAP2;
      end
      ST_GAP2: begin
        alu_a      = prev;
        alu_b      = curr;
        next_state = ST_ADD;
      end
      ST_ADD: begin
        alu_opcode = OP_ADD;
        alu_a      = prev;
        alu_b      = curr;
        next_state = ST_GAP1;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: counter, Fibonacci pair, result and sticky wrap flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '0;
      curr     <= '0;
      cnt      <= '0;
      result_q <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ovf <= 1'b0;
            if (n == '0) begin
              result_q <= '0;
            end else begin
              cnt  <= n;
              prev <= '0;
            end
          end
        end
        ST_SET: begin
          // ALU returns the constant 1 for OP_SET, seeding F(1).
          curr <= alu_o;
        end
        ST_DEC: begin
          cnt <= alu_o;
          if (alu_zero) begin
            result_q <= curr;
          end
        end
        ST_ADD: begin
          curr <= alu_o;
          prev <= curr;
          // An unsigned sum smaller than an addend means the add wrapped.
          if (alu_o < curr) begin
            ovf <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result    = result_q;
  assign overflow  = ovf;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_fib_controller.sv
// Self-checking bench for fib_controller with a behavioural opcode-triggered ALU.
module tb_fib_controller;
  import fib_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] exp_result;
    logic         exp_ovf;
    int           exp_lat;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] n_in;
  logic [W-1:0] alu_o = 4'hF;
  logic         alu_zero;
  logic [2:0]   alu_opcode;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] result;
  logic         overflow;
  logic         busy;
  logic         done;
  state_t       state_dbg;

  int passed = 0;
  int total  = 0;

  logic [2:0] trace_q[$];
  logic [2:0] exp_q[$];

  fib_controller #(.size(W)) dut (
    .clk(clk), .reset(reset), .start(start), .n(n_in),
    .alu_o(alu_o), .alu_zero(alu_zero), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .result(result), .overflow(overflow),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: evaluates only when the opcode changes.
  always @(alu_opcode) begin
    case (alu_opcode)
      3'b001:  alu_o = 4'd1;
      3'b010:  alu_o = alu_a + 4'd1;
      3'b011:  alu_o = alu_a - 4'd1;
      3'b101:  alu_o = alu_a;
      3'b110:  alu_o = alu_a + alu_b;
      3'b111:  alu_o = alu_b;
      default: alu_o = 4'hF;
    endcase
  end
  assign alu_zero = (alu_o == 4'd0);

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: Fibonacci with plain integers, wrap when a true sum exceeds 15.
  function automatic void fib_model(input int nn, output logic [W-1:0] r, output logic o);
    int p, c, s;
    p = 0; c = 1; o = 1'b0;
    if (nn == 0) begin
      r = '0;
      return;
    end
    for (int k = 1; k < nn; k++) begin
      s = p + c;
      if (s > 15) o = 1'b1;
      p = c;
      c = s % 16;
    end
    r = c[W-1:0];
  endfunction

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  // One job: issue start in IDLE, record per-cycle opcodes until done.
  task automatic run_fib(input logic [W-1:0] nn, output logic [W-1:0] r, output logic o,
                         output int lat, output int gap_bad, output int busy_bad);
    logic [2:0] prev_op;
    wait_idle();
    n_in = nn;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    trace_q.delete();
    lat = 0; gap_bad = 0; busy_bad = 0; prev_op = 3'b000;
    while (1) begin
      lat++;
      trace_q.push_back(alu_opcode);
      if (alu_opcode != 3'b000 && prev_op != 3'b000) gap_bad++;
      if (!busy) busy_bad++;
      prev_op = alu_opcode;
      if (done || lat >= 100) break;
      @(posedge clk); #1;
    end
    if (!done) check("run_timeout", 0, 1);
    r = result;
    o = overflow;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_opcode"}, alu_opcode, 0);
    check({nm, "_a"}, alu_a, 0);
    check({nm, "_b"}, alu_b, 0);
    check({nm, "_result"}, result, 0);
    check({nm, "_overflow"}, overflow, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_done"}, done, 0);
    check({nm, "_state"}, state_dbg, ST_IDLE);
  endtask

  initial begin
    vec_t         vecs[6];
    logic [W-1:0] r, mr;
    logic         o, mo;
    int           lat, gb, bb, ndone, guard;
    logic [W-1:0] rn;

    vecs[0] = '{n: 4'd0, exp_result: 4'd0,  exp_ovf: 1'b0, exp_lat: 1};
    vecs[1] = '{n: 4'd1, exp_result: 4'd1,  exp_ovf: 1'b0, exp_lat: 4};
    vecs[2] = '{n: 4'd2, exp_result: 4'd1,  exp_ovf: 1'b0, exp_lat: 8};
    vecs[3] = '{n: 4'd7, exp_result: 4'd13, exp_ovf: 1'b0, exp_lat: 28};
    vecs[4] = '{n: 4'd8, exp_result: 4'd5,  exp_ovf: 1'b1, exp_lat: 32};
    vecs[5] = '{n: 4'd3, exp_result: 4'd2,  exp_ovf: 1'b0, exp_lat: 12};

    // Reset
    reset = 1'b1; start = 1'b0; n_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven runs
    for (int i = 0; i < 6; i++) begin
      run_fib(vecs[i].n, r, o, lat, gb, bb);
      check($sformatf("tbl%0d_result", i), r, vecs[i].exp_result);
      check($sformatf("tbl%0d_overflow", i), o, vecs[i].exp_ovf);
      check($sformatf("tbl%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("tbl%0d_gap_rule", i), gb, 0);
      check($sformatf("tbl%0d_busy", i), bb, 0);
      if (vecs[i].n == 4'd7) begin
        exp_q.delete();
        exp_q.push_back(3'b001);
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b011);
        for (int k = 1; k < 7; k++) begin
          exp_q.push_back(3'b000);
          exp_q.push_back(3'b110);
          exp_q.push_back(3'b000);
          exp_q.push_back(3'b011);
        end
        exp_q.push_back(3'b000);
        check("n7_trace_len", trace_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < trace_q.size(); k++)
          if (trace_q[k] != exp_q[k]) check($sformatf("n7_trace_%0d", k), trace_q[k], exp_q[k]);
        check("n7_trace_head", {trace_q[0], trace_q[1], trace_q[2], trace_q[3], trace_q[4]},
              {3'b001, 3'b000, 3'b011, 3'b000, 3'b110});
      end
    end

    // Randomized runs against the reference model
    for (int i = 0; i < 16; i++) begin
      rn = 4'($urandom_range(0, 15));
      fib_model(int'(rn), mr, mo);
      run_fib(rn, r, o, lat, gb, bb);
      check($sformatf("rnd%0d_n%0d_result", i, rn), r, mr);
      check($sformatf("rnd%0d_n%0d_overflow", i, rn), o, mo);
      check($sformatf("rnd%0d_n%0d_latency", i, rn), lat, (rn == 0) ? 1 : 4 * int'(rn));
      check($sformatf("rnd%0d_gap_rule", i), gb, 0);
    end

    // Reset held 3 cycles, asserted while in ADD of an n=6 run
    wait_idle();
    n_in = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (alu_opcode != 3'b110 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rst_reached_add", alu_opcode, 3'b110);
    reset = 1'b1;
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      check_reset_outputs($sformatf("midrst%0d", k));
    end
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    // start held high for the whole n=5 run: one done only
    wait_idle();
    n_in = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; guard = 0; r = '0;
    while (guard < 40) begin
      if (done) begin
        ndone++;
        r = result;
        start = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    check("pulse_done_count", ndone, 1);
    check("pulse_result", r, 5);

    // start held through DONE: new run starts from the next IDLE cycle
    wait_idle();
    n_in = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    guard = 0;
    while (!done && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    check("hold_first_done", done, 1);
    @(posedge clk); #1;
    check("hold_idle_busy", busy, 0);
    @(posedge clk); #1;
    check("hold_restart_busy", busy, 1);
    check("hold_restart_opcode", alu_opcode, 3'b001);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_second_latency", lat, 8);
    check("hold_second_result", result, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fib_controller.md
# fib_controller

Sequencing FSM for the Fibonacci datapath. On `start` it computes F(n) (F(0)=0, F(1)=1) by driving opcodes and operands into the shared `ALU` instance, then writing the ALU output back into its own operand registers. It also uses the ALU's `zero_flag` as the loop-termination test. It sits between the top-level handshake (`start`/`done`) and the `ALU` inside `fib_top`.

## Interface
- `size`, 4, datapath width; must match the `ALU` `size`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `n`  in  size  sequence index; latched when `start` is accepted.
- `alu_o`  in  size  `ALU.O`.
- `alu_zero`  in  1  `ALU.zero_flag`.
- `alu_opcode`  out  3  to `ALU.alu_opcode`.
- `alu_a`  out  size  to `ALU.A`.
- `alu_b`  out  size  to `ALU.B`.
- `result`  out  size  F(n) mod 2^size; valid from `done` until the next accepted `start`.
- `overflow`  out  1  sticky; set when any addition wrapped.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE.

## Operation
- The ALU is combinational. `O` and `zero_flag` are consumed in the same cycle the opcode is driven.
- The ALU re-evaluates only when its opcode changes. Every real op is therefore preceded by a GAP state driving 3'b000, and no two consecutive cycles carry the same non-zero opcode.
- During a GAP, `alu_a` and `alu_b` already carry the operands of the following op.
- Internal registers: `prev`, `curr`, `cnt` (all `size` bits), plus `ovf`.
- IDLE: opcode 000, a=b=0.
  - `start` with `n==0`: `result`←0, `ovf`←0, go to DONE.
  - `start` with `n>=1`: `cnt`←n, `prev`←0, `ovf`←0, go to SET.
- SET: opcode 001, a=b=0. `curr`←`alu_o` (=1). Go to GAP1.
- GAP1: opcode 000, a=`cnt`, b=0. Go to DEC.
- DEC: opcode 011, a=`cnt`. `cnt`←`alu_o`.
  - `alu_zero`=1: `result`←`curr`, go to DONE.
  - Otherwise go to GAP2.
- GAP2: opcode 000, a=`prev`, b=`curr`. Go to ADD.
- ADD: opcode 110, a=`prev`, b=`curr`. `curr`←`alu_o`, `prev`←`curr`. If `alu_o < curr` (unsigned wrap), `ovf`←1. Go to GAP1.
- DONE: opcode 000, a=b=0, `done`=1. Go to IDLE.
- Arithmetic is modulo 2^size; there is no saturation. `overflow` reflects `ovf` and stays sticky until the next accepted `start`.
- `start` while busy is ignored. `start` held high in IDLE immediately after DONE starts a new run.
- `reset` in any state: go to IDLE; all registers and outputs take their reset values on that edge. Any run in progress is abandoned and produces no `done`.

## Timing
- Reset values: `alu_opcode`=000, `alu_a`=0, `alu_b`=0, `result`=0, `overflow`=0, `busy`=0, `done`=0, state=IDLE.
- `alu_opcode`, `alu_a`, `alu_b`, `busy` and `done` are decoded from the state register plus internal registers, with no input-to-output combinational path.
- Latency: if `start` is accepted at edge T0, `done` is high in the cycle after edge T0+4n−1 (4n cycles after acceptance) for n≥1. For n=0 it is high in the cycle after T0.
- Each loop iteration (GAP2, ADD, GAP1, DEC) takes 4 cycles.
- `busy` is high from the cycle after acceptance through the DONE cycle.

## Structure
- Shared package `fib_pkg`:
  - state enum (IDLE, SET, GAP1, DEC, GAP2, ADD, DONE);
  - opcode constants: OP_NOP=000, OP_SET=001, OP_INC=010, OP_DEC=011, OP_LOAD=101, OP_ADD=110, OP_COPY=111.
- No sub-module. One state register, one next-state block and one register-update block.
- `fib_top` instantiates `fib_controller` and `ALU` side by side.

## Test plan
The bench uses a behavioural ALU implementing the opcode table above, with default output 4'hF.
- Reset held 3 cycles mid-run (n=6, assert in ADD) → next cycle IDLE; all outputs at reset values; no `done` pulse.
- n=0 → `done` in cycle 1 after acceptance, `result`=0, `overflow`=0.
- n=1 → `done` at cycle 4, `result`=1. n=2 → `done` at cycle 8, `result`=1.
- n=7 → `done` at cycle 28, `result`=13, `overflow`=0.
  - Check the opcode trace: 001,000,011,000,110,000,011,…
  - Check that every non-zero opcode is preceded by 000.
- n=8 → `result`=5 (21 mod 16), `overflow`=1. A following run with n=3 → `result`=2, `overflow`=0.
- `start` pulsed every cycle during an n=5 run → exactly one `done`, `result`=5. `start` held high through DONE → a second run begins in the following IDLE cycle.
